// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the receive checker.
// Segment bus layout is {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned DIGIT_W = 4;

   // Bit positions of each segment on the bus.
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   // Glyph table, one entry per BCD digit plus blank.
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // Sequence tracker states.
   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_TRACK    = 1'b1
   } rx_state_e;

endpackage

// File: rtl/seg7_pat_decode.sv
// Combinational glyph decoder: segment pattern -> BCD value / blank / invalid.
// Ports:
//   pattern     - segment bus {g,f,e,d,c,b,a}
//   is_digit_c  - pattern is one of the ten digit glyphs
//   is_blank_c  - pattern is all segments off
//   value_c     - decoded digit (0 when not a digit)
module seg7_pat_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0]   pattern,
   output logic               is_digit_c,
   output logic               is_blank_c,
   output logic [DIGIT_W-1:0] value_c
);

   // Table lookup; anything not listed (including hex A/b glyphs) is invalid.
   always_comb begin
      is_digit_c = 1'b1;
      is_blank_c = 1'b0;
      value_c    = '0;
      case (pattern)
         SEG_0:     value_c = 4'd0;
         SEG_1:     value_c = 4'd1;
         SEG_2:     value_c = 4'd2;
         SEG_3:     value_c = 4'd3;
         SEG_4:     value_c = 4'd4;
         SEG_5:     value_c = 4'd5;
         SEG_6:     value_c = 4'd6;
         SEG_7:     value_c = 4'd7;
         SEG_8:     value_c = 4'd8;
         SEG_9:     value_c = 4'd9;
         SEG_BLANK: begin
            is_digit_c = 1'b0;
            is_blank_c = 1'b1;
         end
         default:   is_digit_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_rx.sv
// Seven-segment receive checker: synchronises the segment bus, waits for a
// stable pattern, decodes it and verifies the displayed digits count up mod 10.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   seg_in       - asynchronous segment bus {g,f,e,d,c,b,a}
//   clear_err    - synchronous clear of err_count (wins over an increment)
//   digit        - last accepted digit
//   digit_valid  - one-cycle pulse per newly accepted digit
//   blank        - last accepted pattern was blank
//   pattern_err  - one-cycle pulse on an accepted undecodable pattern
//   seq_err      - one-cycle pulse on an accepted out-of-sequence digit
//   locked       - a sequence reference digit is held
//   err_count    - saturating count of pattern_err + seq_err events
module seg7_rx
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ERR_W         = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SEG_W-1:0]   seg_in,
   input  logic               clear_err,
   output logic [DIGIT_W-1:0] digit,
   output logic               digit_valid,
   output logic               blank,
   output logic               pattern_err,
   output logic               seq_err,
   output logic               locked,
   output logic [ERR_W-1:0]   err_count
);

   localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] STAB_ACC = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   // Reset value of last_acc; chosen so a blank bus after reset still counts as new.
   localparam logic [SEG_W-1:0] LAST_RST = 7'h7F;

   logic [SEG_W-1:0]   sync1;
   logic [SEG_W-1:0]   sync2;
   logic [SEG_W-1:0]   cand;
   logic [CNT_W-1:0]   stab_cnt;
   logic [SEG_W-1:0]   last_acc;
   rx_state_e          state;

   logic               accept_c;
   logic               is_digit_c;
   logic               is_blank_c;
   logic [DIGIT_W-1:0] value_c;
   logic [DIGIT_W-1:0] next_ref_c;
   logic               pat_err_c;
   logic               seq_err_c;

   seg7_pat_decode u_decode (
      .pattern    (cand),
      .is_digit_c (is_digit_c),
      .is_blank_c (is_blank_c),
      .value_c    (value_c)
   );

   // Accept once the candidate has been seen STABLE_CYCLES times and differs from the last accepted one.
   always_comb begin
      accept_c   = (sync2 == cand) && (stab_cnt == STAB_ACC) && (cand != last_acc);
      next_ref_c = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      pat_err_c  = accept_c && !is_digit_c && !is_blank_c;
      seq_err_c  = accept_c && is_digit_c && (state == ST_TRACK) && (value_c != next_ref_c);
   end

   assign locked = (state == ST_TRACK);

   // Synchroniser, stability filter, sequence tracker and error counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1       <= '0;
         sync2       <= '0;
         cand        <= '0;
         stab_cnt    <= '0;
         last_acc    <= LAST_RST;
         state       <= ST_UNLOCKED;
         digit       <= '0;
         digit_valid <= 1'b0;
         blank       <= 1'b0;
         pattern_err <= 1'b0;
         seq_err     <= 1'b0;
         err_count   <= '0;
      end else begin
         sync1 <= seg_in;
         sync2 <= sync1;

         if (sync2 != cand) begin
            cand     <= sync2;
            stab_cnt <= '0;
         end else if (stab_cnt < STAB_MAX) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
         end

         digit_valid <= 1'b0;
         pattern_err <= pat_err_c;
         seq_err     <= seq_err_c;

         if (accept_c) begin
            last_acc <= cand;
            if (is_blank_c) begin
               // Blank keeps the reference digit so counting resumes across it.
               blank <= 1'b1;
            end else begin
               blank <= 1'b0;
               if (is_digit_c) begin
                  digit       <= value_c;
                  digit_valid <= 1'b1;
                  state       <= ST_TRACK;
               end else begin
                  state <= ST_UNLOCKED;
               end
            end
         end

         if (clear_err) begin
            err_count <= '0;
         end else if ((pat_err_c || seq_err_c) && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg7_rx.sv
// Scoreboard bench for seg7_rx (STABLE_CYCLES=4, ERR_W=2): stimulus pushes the
// expected output snapshot for every accepted pulse; a monitor pops on pulses.
module tb_seg7_rx;

   localparam int unsigned ERR_W = 2;

   typedef struct packed {
      logic       dv;
      logic       pe;
      logic       se;
      logic [3:0] digit;
      logic       blank;
      logic       locked;
      logic [1:0] err;
   } evt_t;

   logic             clk;
   logic             rst_n;
   logic [6:0]       seg_in;
   logic             clear_err;
   logic [3:0]       digit;
   logic             digit_valid;
   logic             blank;
   logic             pattern_err;
   logic             seq_err;
   logic             locked;
   logic [ERR_W-1:0] err_count;

   int total;
   int bad;
   evt_t exp_q[$];

   seg7_rx #(.STABLE_CYCLES(4), .ERR_W(ERR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .clear_err   (clear_err),
      .digit       (digit),
      .digit_valid (digit_valid),
      .blank       (blank),
      .pattern_err (pattern_err),
      .seq_err     (seq_err),
      .locked      (locked),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic evt_t mk(input logic dv, input logic pe, input logic se,
                               input logic [3:0] d, input logic bl,
                               input logic lk, input logic [1:0] e);
      evt_t v;
      v.dv = dv; v.pe = pe; v.se = se; v.digit = d;
      v.blank = bl; v.locked = lk; v.err = e;
      return v;
   endfunction

   function automatic evt_t snap();
      return mk(digit_valid, pattern_err, seq_err, digit, blank, locked, err_count);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, " outputs"}, 32'(snap()), 32'(0));
   endtask

   // Drive a pattern and hold it for n cycles; returns at posedge+1.
   task automatic hold(input logic [6:0] pat, input int n);
      seg_in = pat;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_hold(input logic [6:0] pat, input evt_t e);
      exp_q.push_back(e);
      hold(pat, 8);
   endtask

   // Monitor: every output pulse must match the next expected snapshot.
   always @(negedge clk) begin
      if (digit_valid || pattern_err || seq_err) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got 0x%0h expected none", snap());
         end else begin
            evt_t e;
            e = exp_q.pop_front();
            if (snap() !== e) begin
               bad++;
               $display("FAIL event: got 0x%0h expected 0x%0h", snap(), e);
            end
         end
      end
   end

   logic [6:0] seq_pat [10];

   initial begin
      seq_pat[0] = 7'h3F; seq_pat[1] = 7'h06; seq_pat[2] = 7'h5B; seq_pat[3] = 7'h4F;
      seq_pat[4] = 7'h66; seq_pat[5] = 7'h6D; seq_pat[6] = 7'h7D; seq_pat[7] = 7'h07;
      seq_pat[8] = 7'h7F; seq_pat[9] = 7'h6F;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      seg_in = 7'h3F;
      clear_err = 1'b0;

      // 1: reset then first digit exactly 7 edges after release
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      exp_q.push_back(mk(1, 0, 0, 4'd0, 0, 1, 2'd0));
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("early_valid", 32'(digit_valid), 32'(0));
      @(posedge clk);
      #1;
      check("edge7_valid", 32'(digit_valid), 32'(1));
      hold(7'h3F, 20);

      // 2: full count 1..9,0
      for (int i = 1; i <= 10; i++)
         expect_hold(seq_pat[i % 10], mk(1, 0, 0, 4'(i % 10), 0, 1, 2'd0));
      check("count_err", 32'(err_count), 32'(0));

      // 3: glitch back to accepted pattern, then a real change
      hold(7'h06, 2);
      hold(7'h3F, 10);
      check("glitch_digit", 32'(digit), 32'(0));
      expect_hold(7'h06, mk(1, 0, 0, 4'd1, 0, 1, 2'd0));

      // 4: errors; first count 2..9,0
      for (int i = 2; i <= 10; i++)
         expect_hold(seq_pat[i % 10], mk(1, 0, 0, 4'(i % 10), 0, 1, 2'd0));
      expect_hold(7'h4F, mk(1, 0, 1, 4'd3, 0, 1, 2'd1));
      expect_hold(7'h49, mk(0, 1, 0, 4'd3, 0, 0, 2'd2));
      check("unlocked", 32'(locked), 32'(0));
      expect_hold(7'h6F, mk(1, 0, 0, 4'd9, 0, 1, 2'd2));
      // 9 -> 1 is out of sequence; clear_err lands on the accept edge
      exp_q.push_back(mk(1, 0, 1, 4'd1, 0, 1, 2'd0));
      seg_in = 7'h06;
      repeat (6) @(posedge clk);
      #1;
      clear_err = 1'b1;
      @(posedge clk);
      #1;
      clear_err = 1'b0;
      hold(7'h06, 4);
      check("clear_prio", 32'(err_count), 32'(0));

      // 5: blank keeps the reference digit
      expect_hold(7'h5B, mk(1, 0, 0, 4'd2, 0, 1, 2'd0));
      expect_hold(7'h4F, mk(1, 0, 0, 4'd3, 0, 1, 2'd0));
      expect_hold(7'h66, mk(1, 0, 0, 4'd4, 0, 1, 2'd0));
      hold(7'h00, 8);
      check("blank_set", 32'(blank), 32'(1));
      check("blank_digit", 32'(digit), 32'(4));
      check("blank_locked", 32'(locked), 32'(1));
      expect_hold(7'h6D, mk(1, 0, 0, 4'd5, 0, 1, 2'd0));
      check("blank_clr", 32'(blank), 32'(0));

      // 6: saturation of the 2-bit counter
      expect_hold(7'h49, mk(0, 1, 0, 4'd5, 0, 0, 2'd1));
      expect_hold(7'h3F, mk(1, 0, 0, 4'd0, 0, 1, 2'd1));
      for (int k = 2; k <= 6; k++) begin
         expect_hold(7'h49, mk(0, 1, 0, 4'd0, 0, 0, (k >= 3) ? 2'd3 : 2'(k)));
         expect_hold(7'h3F, mk(1, 0, 0, 4'd0, 0, 1, (k >= 3) ? 2'd3 : 2'(k)));
      end
      check("saturated", 32'(err_count), 32'(3));

      // reset mid-stability, pattern re-qualifies from scratch afterwards
      seg_in = 7'h06;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("mid_reset");
      exp_q.push_back(mk(1, 0, 0, 4'd1, 0, 1, 2'd0));
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("rq_early", 32'(digit_valid), 32'(0));
      @(posedge clk);
      #1;
      check("rq_valid", 32'(digit_valid), 32'(1));
      hold(7'h06, 12);

      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
